// File: rtl/car_pkg.sv
// Shared widths, state encoding and helpers for the vehicle plant model.
package car_pkg;

  localparam int unsigned SPEED_W           = 8;
  localparam int unsigned DIST_W            = 7;
  localparam int unsigned DIST_CALC_W       = 10;
  localparam int unsigned MAX_SPEED_DEFAULT = 200;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RUN      = 2'd1;
  localparam logic [1:0] STOPPING = 2'd2;

  typedef enum logic [1:0] {
    StIdle     = IDLE,
    StRun      = RUN,
    StStopping = STOPPING
  } car_state_e;

  // Clamp a signed intermediate gap into the unsigned [0, 2**DIST_W-1] range.
  function automatic logic [DIST_W-1:0] clamp_dist(input logic signed [DIST_CALC_W-1:0] d);
    logic [DIST_CALC_W-1:0] du;
    du = d;
    if (d[DIST_CALC_W-1]) begin
      return '0;
    end else if (du > DIST_CALC_W'(2 ** DIST_W - 1)) begin
      return '1;
    end else begin
      return du[DIST_W-1:0];
    end
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running physics-tick divider; held at zero while disabled or cleared.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic enable_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q + CntW'(1);
    if (clear_i || !enable_i || (count_q == CntLast)) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick_o = enable_i && (count_q == CntLast);

endmodule

// File: rtl/car_plant_model.sv
// Closed-loop car/sensor plant: integrates speed from accelerate commands and
// the gap to a leading vehicle at a prescaled physics tick.
module car_plant_model
  import car_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 4,
  parameter int unsigned ACC_STEP   = 1,
  parameter int unsigned DEC_STEP   = 1,
  parameter int unsigned MAX_SPEED  = MAX_SPEED_DEFAULT,
  parameter int unsigned DIST_SHIFT = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic [SPEED_W-1:0] start_speed_i,
  input  logic [DIST_W-1:0]  init_distance_i,
  input  logic [SPEED_W-1:0] lead_speed_i,
  input  logic               accelerate_car_i,
  input  logic               unlock_doors_i,
  output logic [SPEED_W-1:0] car_speed_o,
  output logic [DIST_W-1:0]  leading_distance_o,
  output logic               car_stopped_o,
  output logic               update_valid_o,
  output logic               collision_o,
  output logic               door_violation_o
);

  localparam int unsigned SumW = SPEED_W + 1;
  localparam logic [SPEED_W-1:0] MaxSpeed = SPEED_W'(MAX_SPEED);
  localparam logic [SPEED_W-1:0] DecStep  = SPEED_W'(DEC_STEP);
  localparam logic [SumW-1:0]    AccStep  = SumW'(ACC_STEP);

  car_state_e         state_q, state_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic [DIST_W-1:0]  dist_q, dist_d;
  logic               stopped_q, stopped_d;
  logic               valid_q, valid_d;
  logic               coll_q, coll_d;
  logic               door_q, door_d;

  logic               start_accept;
  logic               tick;
  logic               braking;
  logic               moving;
  logic [SumW-1:0]    speed_sum;
  logic [SPEED_W-1:0] speed_inc, speed_dec, start_clamped;
  logic [SPEED_W-1:0] lead_sh, own_sh;
  logic signed [DIST_CALC_W-1:0] dist_calc;
  logic [DIST_W-1:0]  dist_next;

  assign start_accept = (state_q == StIdle) && start_i;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_prescaler (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .enable_i(state_q != StIdle),
    .clear_i (start_accept),
    .tick_o  (tick)
  );

  // Speed and gap arithmetic, all relative to the pre-tick speed.
  always_comb begin
    moving        = (speed_q != '0);
    speed_sum     = {1'b0, speed_q} + AccStep;
    speed_inc     = (speed_sum > {1'b0, MaxSpeed}) ? MaxSpeed : speed_sum[SPEED_W-1:0];
    speed_dec     = (speed_q > DecStep) ? speed_q - DecStep : '0;
    start_clamped = (start_speed_i > MaxSpeed) ? MaxSpeed : start_speed_i;
    lead_sh       = lead_speed_i >> DIST_SHIFT;
    own_sh        = speed_q >> DIST_SHIFT;
    dist_calc     = $signed({{(DIST_CALC_W - DIST_W){1'b0}}, dist_q})
                  + $signed({{(DIST_CALC_W - SPEED_W){1'b0}}, lead_sh})
                  - $signed({{(DIST_CALC_W - SPEED_W){1'b0}}, own_sh});
    dist_next     = clamp_dist(dist_calc);
    // A stop arriving on a tick cycle already brakes that tick.
    braking       = (state_q == StStopping) || ((state_q == StRun) && stop_i);
  end

  always_comb begin
    state_d = state_q;
    speed_d = speed_q;
    dist_d  = dist_q;
    coll_d  = coll_q;
    door_d  = door_q;
    valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          speed_d = start_clamped;
          dist_d  = init_distance_i;
          coll_d  = 1'b0;
          door_d  = 1'b0;
          state_d = (start_clamped != '0) ? StRun : StIdle;
        end
      end
      StRun, StStopping: begin
        if (tick) begin
          valid_d = 1'b1;
          speed_d = (!braking && accelerate_car_i) ? speed_inc : speed_dec;
          dist_d  = dist_next;
          if (moving && (dist_next == '0)) begin
            coll_d = 1'b1;
          end
          if (moving && unlock_doors_i) begin
            door_d = 1'b1;
          end
        end
        if (tick && (speed_d == '0)) begin
          state_d = StIdle;
        end else if ((state_q == StRun) && stop_i) begin
          state_d = StStopping;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    stopped_d = (state_d == StIdle) && (speed_d == '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      speed_q   <= '0;
      dist_q    <= '0;
      stopped_q <= 1'b1;
      valid_q   <= 1'b0;
      coll_q    <= 1'b0;
      door_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      speed_q   <= speed_d;
      dist_q    <= dist_d;
      stopped_q <= stopped_d;
      valid_q   <= valid_d;
      coll_q    <= coll_d;
      door_q    <= door_d;
    end
  end

  assign car_speed_o        = speed_q;
  assign leading_distance_o = dist_q;
  assign car_stopped_o      = stopped_q;
  assign update_valid_o     = valid_q;
  assign collision_o        = coll_q;
  assign door_violation_o   = door_q;

endmodule
